// File: rtl/par_stream_gen_chk.sv
`default_nettype none
// par_stream_gen_chk: streaming odd/even parity generator/checker with a one-stage
// registered valid/ready output, per-frame column (LRC) parity and a saturating error counter.
module par_stream_gen_chk #(
    parameter int N     = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             odd_sel,
    input  logic             chk_mode,
    input  logic             clr_cnt,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N:0]       in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N:0]       out_data,
    output logic             out_last,
    output logic             out_err,
    output logic [N-1:0]     frame_par,
    output logic             frame_valid,
    output logic [CNT_W-1:0] err_cnt,
    output logic             err_sticky
);

    localparam logic [CNT_W-1:0] c_CNT_MAX = '1;
    localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);

    logic             r_out_valid;
    logic [N:0]       r_out_data;
    logic             r_out_last;
    logic             r_out_err;
    logic [N-1:0]     r_lrc;
    logic [N-1:0]     r_frame_par;
    logic             r_frame_valid;
    logic [CNT_W-1:0] r_err_cnt;
    logic             r_err_sticky;

    logic             w_in_ready;
    logic             w_accept;
    logic             w_par;
    logic             w_mis;
    logic [N-1:0]     w_lrc_next;

    assign w_in_ready = ~r_out_valid | out_ready;
    assign w_accept   = in_valid & w_in_ready;
    assign w_par      = (^in_data[N-1:0]) ^ odd_sel;
    // Mismatch only exists in check mode; generate mode never flags an error.
    assign w_mis      = chk_mode & (in_data[N] != w_par);
    assign w_lrc_next = r_lrc ^ in_data[N-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
            r_out_err   <= 1'b0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_out_data  <= chk_mode ? in_data : {w_par, in_data[N-1:0]};
            r_out_last  <= in_last;
            r_out_err   <= w_mis;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lrc         <= '0;
            r_frame_par   <= '0;
            r_frame_valid <= 1'b0;
        end else begin
            r_frame_valid <= w_accept & in_last;
            if (w_accept) begin
                if (in_last) begin
                    r_frame_par <= w_lrc_next;
                    r_lrc       <= '0;
                end else begin
                    r_lrc       <= w_lrc_next;
                end
            end
        end
    end

    // A clear coinciding with a mismatch restarts the count at one rather than zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_cnt    <= '0;
            r_err_sticky <= 1'b0;
        end else if (clr_cnt) begin
            r_err_cnt    <= (w_accept & w_mis) ? c_CNT_ONE : '0;
            r_err_sticky <= w_accept & w_mis;
        end else if (w_accept & w_mis) begin
            r_err_sticky <= 1'b1;
            if (r_err_cnt != c_CNT_MAX) begin
                r_err_cnt <= r_err_cnt + c_CNT_ONE;
            end
        end
    end

    assign in_ready    = w_in_ready;
    assign out_valid   = r_out_valid;
    assign out_data    = r_out_data;
    assign out_last    = r_out_last;
    assign out_err     = r_out_err;
    assign frame_par   = r_frame_par;
    assign frame_valid = r_frame_valid;
    assign err_cnt     = r_err_cnt;
    assign err_sticky  = r_err_sticky;

endmodule
`default_nettype wire

// File: tb/tb_par_stream_gen_chk.sv
`default_nettype none
// tb_par_stream_gen_chk: scoreboard bench; stimulus pushes hand-computed expected words,
// a monitor pops and compares on each output handshake.
module tb_par_stream_gen_chk;

    localparam int N     = 8;
    localparam int CNT_W = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             odd_sel = 1'b0;
    logic             chk_mode = 1'b0;
    logic             clr_cnt = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [N:0]       in_data = '0;
    logic             in_last = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [N:0]       out_data;
    logic             out_last;
    logic             out_err;
    logic [N-1:0]     frame_par;
    logic             frame_valid;
    logic [CNT_W-1:0] err_cnt;
    logic             err_sticky;

    par_stream_gen_chk #(.N(N), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .odd_sel(odd_sel), .chk_mode(chk_mode),
        .clr_cnt(clr_cnt), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .out_err(out_err), .frame_par(frame_par), .frame_valid(frame_valid),
        .err_cnt(err_cnt), .err_sticky(err_sticky)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    int fv_cnt  = 0;
    logic [10:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Monitor: compares {err,last,data} on every completed output handshake.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_output", {21'd0, out_err, out_last, out_data}, 32'hFFFF_FFFF);
            end else begin
                logic [10:0] e;
                e = exp_q.pop_front();
                check("out_word", {21'd0, out_err, out_last, out_data}, {21'd0, e});
            end
        end
        if (rst_n && frame_valid) fv_cnt++;
    end

    // Presents one word, waits (bounded) for its accept, records the expected output.
    task automatic send(input logic [8:0] d, input logic last, input logic odd,
                        input logic chk, input logic [8:0] exp_d, input logic exp_e);
        bit done;
        done     = 1'b0;
        in_data  = d;
        in_last  = last;
        odd_sel  = odd;
        chk_mode = chk;
        in_valid = 1'b1;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back({exp_e, last, exp_d});
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        if (!done) check("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    int          fv0;
    logic [8:0]  held;

    initial begin
        #12 rst_n = 1'b1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_frame_par", 32'(frame_par), 32'd0);
        check("rst_err_cnt", 32'(err_cnt), 32'd0);
        check("rst_err_sticky", 32'(err_sticky), 32'd0);
        @(posedge clk);
        #1;

        // Generate mode, odd and even parity.
        send(9'h0A5, 1'b1, 1'b1, 1'b0, 9'h1A5, 1'b0);
        send(9'h0A5, 1'b1, 1'b0, 1'b0, 9'h0A5, 1'b0);
        // Check mode: good then bad word.
        send(9'h1A5, 1'b1, 1'b1, 1'b1, 9'h1A5, 1'b0);
        check("good_err_cnt", 32'(err_cnt), 32'd0);
        send(9'h0A5, 1'b1, 1'b1, 1'b1, 9'h0A5, 1'b1);
        check("bad_err_cnt", 32'(err_cnt), 32'd1);
        check("bad_sticky", 32'(err_sticky), 32'd1);
        in_valid = 1'b0;
        clr_cnt  = 1'b1;
        @(posedge clk);
        #1;
        clr_cnt = 1'b0;
        check("clr_err_cnt", 32'(err_cnt), 32'd0);
        check("clr_sticky", 32'(err_sticky), 32'd0);
        idle(2);

        // Backpressure: one word held for 3 cycles, then back-to-back stream.
        out_ready = 1'b0;
        send(9'h033, 1'b1, 1'b1, 1'b0, 9'h133, 1'b0);
        in_valid = 1'b0;
        held = out_data;
        check("bp_held_value", 32'(held), 32'h133);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_out_data", 32'(out_data), 32'(held));
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        send(9'h001, 1'b1, 1'b1, 1'b0, 9'h001, 1'b0);
        check("b2b_valid0", 32'(out_valid), 32'd1);
        send(9'h003, 1'b1, 1'b1, 1'b0, 9'h103, 1'b0);
        check("b2b_valid1", 32'(out_valid), 32'd1);
        send(9'h007, 1'b1, 1'b0, 1'b0, 9'h107, 1'b0);
        check("b2b_valid2", 32'(out_valid), 32'd1);
        idle(2);

        // Three-word frame then a single-word frame.
        fv0 = fv_cnt;
        send(9'h00F, 1'b0, 1'b0, 1'b0, 9'h00F, 1'b0);
        send(9'h0F0, 1'b0, 1'b0, 1'b0, 9'h0F0, 1'b0);
        send(9'h03C, 1'b1, 1'b0, 1'b0, 9'h03C, 1'b0);
        idle(3);
        check("frame3_par", 32'(frame_par), 32'hC3);
        check("frame3_pulses", 32'(fv_cnt - fv0), 32'd1);
        send(9'h081, 1'b1, 1'b0, 1'b0, 9'h081, 1'b0);
        idle(2);
        check("frame1_par", 32'(frame_par), 32'h81);

        // Saturation at 3 with a 2-bit counter.
        for (int i = 0; i < 5; i++) send(9'h0A5, 1'b1, 1'b1, 1'b1, 9'h0A5, 1'b1);
        idle(1);
        check("sat_err_cnt", 32'(err_cnt), 32'd3);

        // Clear coinciding with a bad word.
        clr_cnt = 1'b1;
        send(9'h0A5, 1'b1, 1'b1, 1'b1, 9'h0A5, 1'b1);
        clr_cnt = 1'b0;
        check("clr_bad_cnt", 32'(err_cnt), 32'd1);
        check("clr_bad_sticky", 32'(err_sticky), 32'd1);
        idle(2);

        // Reset mid-frame with a pending output word.
        out_ready = 1'b0;
        send(9'h0A5, 1'b0, 1'b1, 1'b1, 9'h0A5, 1'b1);
        in_valid = 1'b0;
        check("pre_rst_valid", 32'(out_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_valid", 32'(out_valid), 32'd0);
        check("rst_mid_frame_par", 32'(frame_par), 32'd0);
        check("rst_mid_err_cnt", 32'(err_cnt), 32'd0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        send(9'h055, 1'b1, 1'b0, 1'b0, 9'h055, 1'b0);
        idle(3);
        check("post_rst_frame_par", 32'(frame_par), 32'h55);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/par_stream_gen_chk.md
Name: par_stream_gen_chk

Overview:
- Streaming, parametrised parity engine: successor to the combinational odd parity generator.
- Per-word parity, selectable odd or even at run time.
- Two modes:
  - generate: appends the parity bit to each word.
  - check: verifies the parity bit that arrives with each word.
- Also accumulates a longitudinal (column) parity word per frame and keeps a saturating error counter.
- Sits between a producer and a consumer on a valid/ready stream, with a one-stage registered output.

Parameters:
- N, 8, data width in bits; N>=2.
- CNT_W, 8, error counter width; CNT_W>=1.

Ports:
- clk  input  1  clock; all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- odd_sel  input  1  1 = odd parity, 0 = even parity; sampled per accepted word.
- chk_mode  input  1  0 = generate, 1 = check; sampled per accepted word.
- clr_cnt  input  1  synchronous clear of err_cnt and err_sticky.
- in_valid  input  1  input word valid.
- in_ready  output  1  block can accept a word.
- in_data  input  N+1  [N-1:0] data; [N] received parity (check mode), ignored in generate mode.
- in_last  input  1  marks the last word of a frame.
- out_valid  output  1  output word valid.
- out_ready  input  1  consumer accepts the output word.
- out_data  output  N+1  [N-1:0] data; [N] parity bit.
- out_last  output  1  registered copy of in_last.
- out_err  output  1  parity mismatch on this word; always 0 in generate mode.
- frame_par  output  N  column parity of the last completed frame.
- frame_valid  output  1  one-cycle pulse when frame_par updates.
- err_cnt  output  CNT_W  saturating count of mismatched words.
- err_sticky  output  1  set on the first mismatch, held until clr_cnt.

Behaviour:
- Reset (rst_n=0, asynchronous): all outputs, output register, LRC accumulator, err_cnt and err_sticky go to 0; in_ready=1.
- Transfers:
  - accept = in_valid & in_ready.
  - in_ready = ~out_valid | out_ready (pipeline register, full throughput).
  - Output handshake completes when out_valid & out_ready.
- Parity: p = (XOR of in_data[N-1:0]) XOR odd_sel.
  - With odd_sel=1, the total count of ones in {p, data} is odd.
- Latency: a word accepted in cycle t appears on out_* in cycle t+1.
- Generate mode: out_data = {p, in_data[N-1:0]}, out_err = 0.
- Check mode: out_data = in_data unchanged, out_err = (in_data[N] != p).
- Backpressure: while out_valid & ~out_ready, out_data, out_last, out_err and out_valid hold stable and no input is accepted.
- out_valid:
  - set on accept;
  - cleared on output handshake without a new accept;
  - stays 1 on simultaneous handshake and accept, taking the new word.
- odd_sel and chk_mode may change every word, including mid-frame; each word uses the values at its own accept.
- LRC accumulator (N bits):
  - on accept with in_last=0: lrc <= lrc ^ in_data[N-1:0].
  - on accept with in_last=1: frame_par <= lrc ^ in_data[N-1:0], lrc <= 0, frame_valid=1 in cycle t+1 (aligned with out_valid for that word, independent of out_ready).
  - frame_valid is 0 otherwise.
  - A single-word frame (in_last on the first word) gives frame_par = that word's data.
- Error counter: updated on accept of a word with mismatch (check mode only).
  - err_cnt increments, saturating at 2^CNT_W-1.
  - err_sticky <= 1.
- clr_cnt:
  - clears err_cnt and err_sticky next cycle.
  - If a mismatch is accepted in the same cycle, the result is err_cnt=1, err_sticky=1.
  - Does not affect the output register, the LRC or frame_par.
- rst_n asserted mid-frame: any pending output word is dropped, the LRC is discarded, frame_par returns to 0.

Test Plan:
- Generate, odd_sel=1, N=8, in_data[7:0]=8'hA5 (four ones), out_ready=1:
  - next cycle out_data=9'h1A5, out_err=0.
  - with odd_sel=0, out_data=9'h0A5.
- Check, odd_sel=1:
  - in_data=9'h1A5 -> out_err=0, err_cnt=0.
  - in_data=9'h0A5 -> out_err=1, err_cnt=1, err_sticky=1.
  - then clr_cnt=1 -> err_cnt=0, err_sticky=0.
- Backpressure: hold out_ready=0 for 3 cycles after one accept:
  - in_ready=0, out_data is constant.
  - raise out_ready together with in_valid=1 -> back-to-back transfer, out_valid stays 1, one word per cycle.
- Frame of 3 words (8'h0F, 8'hF0, 8'h3C with in_last on the third):
  - frame_par=8'hC3, frame_valid pulses exactly once.
  - next frame of 1 word (8'h81, last) -> frame_par=8'h81.
- CNT_W=2, check mode, 5 consecutive bad words -> err_cnt saturates at 3.
- Same-cycle clr_cnt and bad word -> err_cnt=1.
- Assert rst_n=0 mid-frame with out_valid=1:
  - out_valid, frame_par and err_cnt go to 0 immediately.
  - after release, a 1-word frame 8'h55 gives frame_par=8'h55.
